i2c_slave: RTL and testbench

// - I2C target (slave) answering the team's I2C master on the shared i2c_sc1/i2c_sda bus.
// - Oversamples SCL/SDA on the system clock.
// - Detects START, repeated START and STOP; matches a 7-bit address.
// - Writes: first data byte loads the register pointer; later bytes go to an external register port.
// - Reads: returns external register data from the pointer, auto-incrementing.
//

---
 rtl/i2c_slave_if.sv | 27 ++
 rtl/i2c_slave.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: register-port bundle between the I2C target and its register file.
// The target drives pointer/write strobe/busy; the register file returns read data.
interface i2c_slave_if #(
    parameter int PTR_W = 8
);
    logic [PTR_W-1:0] reg_addr;
    logic [7:0]       reg_wdata;
    logic             reg_we;
    logic [7:0]       reg_rdata;
    logic             busy;

    modport slave (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output busy,
        input  reg_rdata
    );

    modport master (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  busy,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with auto-incrementing register pointer.
// Define I2C_SLAVE_GCALL_EN to also ACK the general call address byte 8'h00.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         PTR_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sc1,
    inout  wire        i2c_sda,
    i2c_slave_if.slave regs
);

`ifdef I2C_SLAVE_GCALL_EN
    localparam bit GCALL = 1'b1;
`else
    localparam bit GCALL = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;
    logic [PTR_W-1:0] ptr;
    logic             sda_oe;
    logic             ack_on;
    logic             rw;
    logic             first;
    logic             busy_q;
    logic             we_q;
    logic [7:0]       wdata_q;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] byte_in;
    logic       addr_hit;

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    assign regs.reg_addr  = ptr;
    assign regs.reg_wdata = wdata_q;
    assign regs.reg_we    = we_q;
    assign regs.busy      = busy_q;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_sc1};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign byte_in  = {shreg, sda_s};
    assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) ||
                      (GCALL && (byte_in == 8'h00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            ack_on  <= 1'b0;
            rw      <= 1'b0;
            first   <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            // pointer advances the clk after the write strobe
            if (we_q) ptr <= ptr + PTR_W'(1);

            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                busy_q <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                unique case (state)
                    IDLE, WAIT_STOP: begin
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shreg <= byte_in[6:0];
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                rw      <= sda_s;
                                first   <= 1'b1;
                                state   <= addr_hit ? ADDR_ACK : WAIT_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ADDR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                ack_on  <= 1'b0;
                                bit_cnt <= '0;
                                if (state == WR_ACK || !rw) begin
                                    sda_oe <= 1'b0;
                                    state  <= WR_BYTE;
                                end else begin
                                    // first read bit goes out on the ACK-ending fall
                                    shreg  <= regs.reg_rdata[6:0];
                                    sda_oe <= ~regs.reg_rdata[7];
                                    ptr    <= ptr + PTR_W'(1);
                                    state  <= RD_BYTE;
                                end
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shreg <= byte_in[6:0];
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                state   <= WR_ACK;
                                if (first) begin
                                    first <= 1'b0;
                                    ptr   <= PTR_W'(byte_in);
                                end else begin
                                    we_q    <= 1'b1;
                                    wdata_q <= byte_in;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                sda_oe  <= 1'b0;
                                state   <= RD_ACK;
                            end else begin
                                shreg   <= {shreg[5:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (!ack_on) begin
                            if (scl_rise) begin
                                if (sda_s) state  <= WAIT_STOP;
                                else       ack_on <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            shreg   <= regs.reg_rdata[6:0];
                            sda_oe  <= ~regs.reg_rdata[7];
                            ptr     <= ptr + PTR_W'(1);
                            state   <= RD_BYTE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-level I2C master driving the target, with table vectors,
// hand-written corner sequences and a randomized pointer/register model.
module tb_i2c_slave;
    localparam int Q = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_if #(.PTR_W(8)) rif ();
    assign rif.reg_rdata = ~rif.reg_addr;

    i2c_slave #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2),
        .PTR_W      (8)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .i2c_sc1(scl),
        .i2c_sda(sda),
        .regs   (rif)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] we_q[$];
    bit          dut_low = 1'b0;
    logic        busy_mid = 1'b0;
    logic [7:0]  wbuf[4];
    logic [7:0]  rbuf[4];

    always @(negedge clk) begin
        if (rif.reg_we) we_q.push_back({rif.reg_addr, rif.reg_wdata});
        if (sda === 1'b0 && !m_low) dut_low = 1'b1;
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", n, got, exp);
    endtask

    task automatic chk_we(input string n, input int j, input logic [7:0] a, input logic [7:0] d);
        if (j < we_q.size()) begin
            chk(n, {16'h0, we_q[j]}, {16'h0, a, d});
        end else begin
            n_chk++;
            $display("FAIL %s: missing write, expected addr %02h data %02h", n, a, d);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        waitc(Q); m_low = 1'b0;
        waitc(Q); scl = 1'b1;
        waitc(Q); m_low = 1'b1;
        waitc(Q); scl = 1'b0;
    endtask

    task automatic bus_stop();
        waitc(Q); m_low = 1'b1;
        waitc(Q); scl = 1'b1;
        waitc(Q); m_low = 1'b0;
        waitc(Q);
    endtask

    task automatic write_bit(input bit b);
        waitc(Q); m_low = ~b;
        waitc(Q); scl = 1'b1;
        waitc(2 * Q); scl = 1'b0;
    endtask

    task automatic read_bit(output bit b);
        waitc(Q); m_low = 1'b0;
        waitc(Q); scl = 1'b1;
        waitc(Q); b = (sda !== 1'b0);
        waitc(Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input bit ack, output logic [7:0] d);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic wr_txn(input logic [7:0] ab, input int nw, output bit aack, output int dacks);
        bit k;
        dacks = 0;
        bus_start();
        write_byte(ab, aack);
        busy_mid = rif.busy;
        if (aack) begin
            for (int i = 0; i < nw; i++) begin
                write_byte(wbuf[i], k);
                if (k) dacks++;
            end
        end
        bus_stop();
    endtask

    task automatic rd_txn(input bit setp, input logic [7:0] p, input int nr, output bit aack);
        bit k;
        aack = 1'b1;
        bus_start();
        if (setp) begin
            write_byte(8'hA0, k); aack &= k;
            write_byte(p, k);     aack &= k;
            bus_start();
        end
        write_byte(8'hA1, k); aack &= k;
        busy_mid = rif.busy;
        for (int i = 0; i < nr; i++) read_byte(i < nr - 1, rbuf[i]);
        bus_stop();
    endtask

    typedef struct packed {
        logic [7:0]      abyte;
        int              nw;
        logic [0:2][7:0] d;
        bit              ack;
        int              nwe;
        logic [0:1][7:0] ea;
        logic [0:1][7:0] ed;
    } wvec_t;

    wvec_t      vt[6];
    bit         aack;
    bit         b;
    int         dacks;
    int         kind;
    int         nw;
    int         nr;
    logic [7:0] ab;
    logic [7:0] p;
    logic [7:0] mptr;
    logic [15:0] exp_q[$];

    initial begin
        vt[0] = '{8'hA0, 3, {8'h10, 8'h5A, 8'hC3}, 1'b1, 2, {8'h10, 8'h11}, {8'h5A, 8'hC3}};
        vt[1] = '{8'hA2, 0, {8'h00, 8'h00, 8'h00}, 1'b0, 0, {8'h00, 8'h00}, {8'h00, 8'h00}};
        vt[2] = '{8'hA0, 3, {8'hFF, 8'h11, 8'h22}, 1'b1, 2, {8'hFF, 8'h00}, {8'h11, 8'h22}};
        vt[3] = '{8'hA0, 3, {8'h7F, 8'h00, 8'hFF}, 1'b1, 2, {8'h7F, 8'h80}, {8'h00, 8'hFF}};
        vt[4] = '{8'hA0, 1, {8'h33, 8'h00, 8'h00}, 1'b1, 0, {8'h00, 8'h00}, {8'h00, 8'h00}};
        vt[5] = '{8'hA4, 0, {8'h00, 8'h00, 8'h00}, 1'b0, 0, {8'h00, 8'h00}, {8'h00, 8'h00}};

        waitc(5);
        chk("rst_addr", {24'h0, rif.reg_addr}, 32'h0);
        chk("rst_wdata", {24'h0, rif.reg_wdata}, 32'h0);
        chk("rst_we", {31'h0, rif.reg_we}, 32'h0);
        chk("rst_busy", {31'h0, rif.busy}, 32'h0);
        chk("rst_sda", {31'h0, sda !== 1'b0}, 32'h1);
        rst = 1'b0;
        waitc(5);

        for (int v = 0; v < 6; v++) begin
            we_q.delete();
            dut_low = 1'b0;
            for (int j = 0; j < 3; j++) wbuf[j] = vt[v].d[j];
            wr_txn(vt[v].abyte, vt[v].nw, aack, dacks);
            chk($sformatf("t%0d_aack", v), {31'h0, aack}, {31'h0, vt[v].ack});
            chk($sformatf("t%0d_dacks", v), dacks, vt[v].ack ? vt[v].nw : 0);
            chk($sformatf("t%0d_nwe", v), we_q.size(), vt[v].nwe);
            for (int j = 0; j < vt[v].nwe; j++)
                chk_we($sformatf("t%0d_we%0d", v, j), j, vt[v].ea[j], vt[v].ed[j]);
            chk($sformatf("t%0d_busy_mid", v), {31'h0, busy_mid}, 32'h1);
            chk($sformatf("t%0d_busy_end", v), {31'h0, rif.busy}, 32'h0);
            chk($sformatf("t%0d_drove", v), {31'h0, dut_low}, {31'h0, vt[v].ack});
        end

        we_q.delete();
        rd_txn(1'b1, 8'h20, 2, aack);
        chk("rd_aack", {31'h0, aack}, 32'h1);
        chk("rd_byte0", {24'h0, rbuf[0]}, 32'hDF);
        chk("rd_byte1", {24'h0, rbuf[1]}, 32'hDE);
        chk("rd_ptr", {24'h0, rif.reg_addr}, 32'h22);
        chk("rd_nwe", we_q.size(), 0);
        chk("rd_busy_end", {31'h0, rif.busy}, 32'h0);

        bus_start();
        write_byte(8'hA0, aack);
        write_byte(8'hFF, aack);
        bus_start();
        write_byte(8'hA1, aack);
        chk("mid_aack", {31'h0, aack}, 32'h1);
        for (int i = 0; i < 3; i++) read_bit(b);
        waitc(Q);
        chk("mid_sda_low", {31'h0, sda === 1'b0}, 32'h1);
        chk("mid_busy", {31'h0, rif.busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_sda", {31'h0, sda !== 1'b0}, 32'h1);
        chk("mid_rst_busy", {31'h0, rif.busy}, 32'h0);
        waitc(3);
        rst = 1'b0;
        waitc(Q);
        scl = 1'b1;
        waitc(Q);
        we_q.delete();
        wbuf[0] = 8'h05;
        wbuf[1] = 8'h99;
        wr_txn(8'hA0, 2, aack, dacks);
        chk("post_rst_aack", {31'h0, aack}, 32'h1);
        chk("post_rst_nwe", we_q.size(), 1);
        chk_we("post_rst_we", 0, 8'h05, 8'h99);

        we_q.delete();
        dut_low = 1'b0;
        wbuf[0] = 8'h10;
        wbuf[1] = 8'h77;
        wr_txn(8'h00, 2, aack, dacks);
`ifdef I2C_SLAVE_GCALL_EN
        chk("gc_aack", {31'h0, aack}, 32'h1);
        chk("gc_nwe", we_q.size(), 1);
        chk_we("gc_we", 0, 8'h10, 8'h77);
`else
        chk("gc_aack", {31'h0, aack}, 32'h0);
        chk("gc_nwe", we_q.size(), 0);
        chk("gc_drove", {31'h0, dut_low}, 32'h0);
`endif
        we_q.delete();
        dut_low = 1'b0;
        wr_txn(8'h01, 2, aack, dacks);
        chk("g1_aack", {31'h0, aack}, 32'h0);
        chk("g1_nwe", we_q.size(), 0);
        chk("g1_drove", {31'h0, dut_low}, 32'h0);

        mptr = 8'h00;
        for (int t = 0; t < 10; t++) begin
            kind = (t == 0) ? 0 : int'($urandom_range(0, 3));
            we_q.delete();
            exp_q.delete();
            dut_low = 1'b0;
            if (kind == 0) begin
                nw = int'($urandom_range(1, 3));
                for (int i = 0; i < nw; i++) wbuf[i] = 8'($urandom);
                mptr = wbuf[0];
                for (int i = 1; i < nw; i++) begin
                    exp_q.push_back({mptr, wbuf[i]});
                    mptr = mptr + 8'd1;
                end
                wr_txn(8'hA0, nw, aack, dacks);
                chk($sformatf("r%0d_aack", t), {31'h0, aack}, 32'h1);
                chk($sformatf("r%0d_dacks", t), dacks, nw);
                chk($sformatf("r%0d_nwe", t), we_q.size(), exp_q.size());
                for (int j = 0; j < exp_q.size(); j++)
                    chk_we($sformatf("r%0d_we%0d", t, j), j, exp_q[j][15:8], exp_q[j][7:0]);
            end else if (kind == 3) begin
                ab = 8'($urandom);
                if (ab[7:1] == 7'h50 || ab[7:1] == 7'h00) ab[7:1] = 7'h3C;
                wbuf[0] = 8'($urandom);
                wr_txn(ab, 1, aack, dacks);
                chk($sformatf("r%0d_bad_aack", t), {31'h0, aack}, 32'h0);
                chk($sformatf("r%0d_bad_nwe", t), we_q.size(), 0);
                chk($sformatf("r%0d_bad_drove", t), {31'h0, dut_low}, 32'h0);
            end else begin
                nr = int'($urandom_range(1, 2));
                p = 8'($urandom);
                if (kind == 2) mptr = p;
                rd_txn(kind == 2, p, nr, aack);
                chk($sformatf("r%0d_rd_aack", t), {31'h0, aack}, 32'h1);
                for (int i = 0; i < nr; i++) begin
                    chk($sformatf("r%0d_rd%0d", t, i), {24'h0, rbuf[i]}, {24'h0, ~mptr});
                    mptr = mptr + 8'd1;
                end
            end
            chk($sformatf("r%0d_busy_end", t), {31'h0, rif.busy}, 32'h0);
        end
        chk("final_ptr", {24'h0, rif.reg_addr}, {24'h0, mptr});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
